icache_direct_mapped: RTL

//  Direct-mapped instruction cache between the CPU fetch stage and the 128-bit block instruction memory.

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_line_array.sv | 49 ++++
 rtl/icache_direct_mapped.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and field geometry for the direct-mapped instruction cache.
// Slice helpers return bit positions so callers can derive constant localparams.
package icache_pkg;

    localparam int unsigned WORD_SEL_W = 2;
    localparam int unsigned BLK_OFF_W  = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned WORDS      = BLOCK_W / WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FILL
    } state_t;

    // Lowest bit of the word-select field within a byte address.
    function automatic int unsigned word_lsb();
        return BLK_OFF_W - WORD_SEL_W;
    endfunction

    // Lowest bit of the tag field within a byte address.
    function automatic int unsigned tag_lsb(input int unsigned idx_w);
        return BLK_OFF_W + idx_w;
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned idx_w);
        return addr_w - BLK_OFF_W - idx_w;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Line storage: tag/data arrays with one combinational read port and one synchronous
// write port, plus the valid vector (async reset clear, synchronous flush clear).
module icache_line_array
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned TAG_W     = 25
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic [IDX_W-1:0]   rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data
);

    logic [BLOCK_W-1:0]   data_mem [NUM_LINES];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            data_mem[wr_index] <= wr_data;
            tag_mem[wr_index]  <= wr_tag;
        end
    end

    // Flush wins over a same-edge write so a pending invalidate can never be lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    assign rd_data  = data_mem[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: zero-latency hits, blocking 16-byte refill on miss,
// OS flush (deferred while a refill is in flight) and saturating hit/miss counters.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic [ADDR_W-1:0]     cpu_address,
    output logic [WORD_W-1:0]     cpu_instr,
    output logic                  cpu_busywait,
    input  logic                  flush,
    output logic                  mem_read,
    output logic [ADDR_W-5:0]     mem_address,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    localparam int unsigned IDX_W   = $clog2(NUM_LINES);
    localparam int unsigned TAG_LSB = tag_lsb(IDX_W);
    localparam int unsigned TAG_W   = tag_width(ADDR_W, IDX_W);
    localparam int unsigned WSEL_LO = word_lsb();

    state_t state, next_state;

    logic [WORD_SEL_W-1:0] word_sel;
    logic [IDX_W-1:0]      index;
    logic [TAG_W-1:0]      tag;
    logic                  unused_byte_sel;

    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;
    logic                  line_valid;
    logic                  hit;
    logic [WORD_W-1:0]     hit_word;

    logic [IDX_W-1:0]      fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic                  flush_pending;

    logic                  flush_now;
    logic                  fill_en;
    logic                  latch_miss;
    logic                  hit_inc;
    logic                  miss_inc;

    assign word_sel        = cpu_address[BLK_OFF_W-1:WSEL_LO];
    assign index           = cpu_address[TAG_LSB-1:BLK_OFF_W];
    assign tag             = cpu_address[ADDR_W-1:TAG_LSB];
    assign unused_byte_sel = ^cpu_address[WSEL_LO-1:0];

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush_now),
        .rd_index (index),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .rd_valid (line_valid),
        .wr_en    (fill_en),
        .wr_index (fill_index),
        .wr_tag   (fill_tag),
        .wr_data  (mem_readdata)
    );

    assign hit = cpu_read & line_valid & (line_tag == tag);

    always_comb begin
        hit_word = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (word_sel == WORD_SEL_W'(w)) begin
                hit_word = line_data[w*WORD_W +: WORD_W];
            end
        end
    end

    assign cpu_instr   = hit ? hit_word : '0;
    assign mem_address = {fill_tag, fill_index};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // An external flush or a deferred one turns the IDLE lookup into a count-free stall.
    always_comb begin
        next_state   = state;
        cpu_busywait = 1'b0;
        mem_read     = 1'b0;
        fill_en      = 1'b0;
        latch_miss   = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        flush_now    = 1'b0;
        unique case (state)
            IDLE: begin
                flush_now = flush | flush_pending;
                if (flush_now) begin
                    cpu_busywait = cpu_read;
                end else if (hit) begin
                    hit_inc = 1'b1;
                end else if (cpu_read) begin
                    cpu_busywait = 1'b1;
                    latch_miss   = 1'b1;
                    miss_inc     = 1'b1;
                    next_state   = FETCH;
                end
            end
            FETCH: begin
                mem_read     = 1'b1;
                cpu_busywait = 1'b1;
                if (!mem_busywait) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                cpu_busywait = 1'b1;
                fill_en      = 1'b1;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_index <= '0;
            fill_tag   <= '0;
        end else if (latch_miss) begin
            fill_index <= index;
            fill_tag   <= tag;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_pending <= 1'b0;
        end else if (state != IDLE) begin
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end else begin
            flush_pending <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule
